// File: rtl/ir_nec_pkg.sv
// Shared types and default timing for the NEC IR transmitter (cycle counts at 50 MHz).
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LO,
    ST_LEAD_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_STOP_LO,
    ST_GAP
  } nec_state_e;

  localparam int FRAME_BITS      = 32;
  localparam int DEF_LEAD_LO     = 450000;
  localparam int DEF_LEAD_HI     = 225000;
  localparam int DEF_BIT_LO      = 28000;
  localparam int DEF_ZERO_HI     = 28000;
  localparam int DEF_ONE_HI      = 84500;
  localparam int DEF_GAP_HI      = 2000000;
  localparam int DEF_CARRIER_DIV = 1316;
  localparam int DEF_CW          = 22;

endpackage

// File: rtl/ir_carrier_gen.sv
// 50%-duty carrier square wave; restarts with a high half-period whenever iEN rises.
module ir_carrier_gen #(
  parameter int DIV = 1316
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iEN,
  output logic oCARRIER
);

  localparam int HALF = DIV / 2;
  localparam int HW   = $clog2(HALF + 1);
  localparam logic [HW-1:0] HALF_END = HW'(HALF - 1);

  logic [HW-1:0] cnt;

  // Held in the restart condition while disabled so the next burst opens high.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt      <= '0;
      oCARRIER <= 1'b1;
    end else if (!iEN) begin
      cnt      <= '0;
      oCARRIER <= 1'b1;
    end else if (cnt == HALF_END) begin
      cnt      <= '0;
      oCARRIER <= ~oCARRIER;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC IR frame transmitter: leader, 32 LSB-first data bits, stop burst, idle gap.
// Define IR_CARRIER_EN to modulate oIR_LED with the 38 kHz carrier during bursts.
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
`ifdef IR_CARRIER_EN
  parameter int CARRIER_DIV = DEF_CARRIER_DIV,
`endif
  parameter int LEAD_LO = DEF_LEAD_LO,
  parameter int LEAD_HI = DEF_LEAD_HI,
  parameter int BIT_LO  = DEF_BIT_LO,
  parameter int ZERO_HI = DEF_ZERO_HI,
  parameter int ONE_HI  = DEF_ONE_HI,
  parameter int GAP_HI  = DEF_GAP_HI,
  parameter int CW      = DEF_CW
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic [15:0] iCUSTOM,
  input  logic [7:0]  iKEY,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oIRDA,
  output logic        oIR_LED
);

  localparam int IW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] LEAD_LO_END = CW'(LEAD_LO - 1);
  localparam logic [CW-1:0] LEAD_HI_END = CW'(LEAD_HI - 1);
  localparam logic [CW-1:0] BIT_LO_END  = CW'(BIT_LO - 1);
  localparam logic [CW-1:0] ZERO_HI_END = CW'(ZERO_HI - 1);
  localparam logic [CW-1:0] ONE_HI_END  = CW'(ONE_HI - 1);
  localparam logic [CW-1:0] GAP_HI_END  = CW'(GAP_HI - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(FRAME_BITS - 1);

  nec_state_e            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FRAME_BITS-1:0] frame;
  logic                  irda;
  logic                  burst;
  logic                  busy;
  logic                  done;

  // Every phase: counter starts at 0 on entry, the phase ends on the edge where cnt hits N-1.
  // burst is kept as its own register so the LED path is never a decode of irda.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
      irda  <= 1'b1;
      burst <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            frame <= {~iKEY, iKEY, iCUSTOM};
            idx   <= '0;
            cnt   <= '0;
            irda  <= 1'b0;
            burst <= 1'b1;
            busy  <= 1'b1;
            state <= ST_LEAD_LO;
          end
        end
        ST_LEAD_LO: begin
          if (cnt == LEAD_LO_END) begin
            cnt   <= '0;
            irda  <= 1'b1;
            burst <= 1'b0;
            state <= ST_LEAD_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LEAD_HI: begin
          if (cnt == LEAD_HI_END) begin
            cnt   <= '0;
            irda  <= 1'b0;
            burst <= 1'b1;
            state <= ST_BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BIT_LO: begin
          if (cnt == BIT_LO_END) begin
            cnt   <= '0;
            irda  <= 1'b1;
            burst <= 1'b0;
            state <= ST_BIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BIT_HI: begin
          if (cnt == (frame[idx] ? ONE_HI_END : ZERO_HI_END)) begin
            cnt   <= '0;
            irda  <= 1'b0;
            burst <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= ST_STOP_LO;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_BIT_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP_LO: begin
          if (cnt == BIT_LO_END) begin
            cnt   <= '0;
            irda  <= 1'b1;
            burst <= 1'b0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_HI_END) begin
            cnt   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          irda  <= 1'b1;
          burst <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oIRDA = irda;
  assign oBUSY = busy;
  assign oDONE = done;

`ifdef IR_CARRIER_EN
  logic carrier;

  ir_carrier_gen #(
    .DIV(CARRIER_DIV)
  ) u_carrier (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iEN     (burst),
    .oCARRIER(carrier)
  );

  assign oIR_LED = burst & carrier;
`else
  assign oIR_LED = burst;
`endif

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Self-checking bench for ir_nec_transmit with shortened phase lengths; waveform is
// captured as (level, length) runs and compared to a frame-level model of the NEC format.
module tb_ir_nec_transmit;

  localparam int LL  = 40;
  localparam int LH  = 20;
  localparam int BL  = 3;
  localparam int ZH  = 3;
  localparam int OH  = 7;
  localparam int GH  = 25;
  localparam int CWB = 8;
`ifdef IR_CARRIER_EN
  localparam int CD  = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] custom = '0;
  logic [7:0]  key = '0;
  logic        busy, done, irda, led;

  int checks = 0;
  int errors = 0;

  ir_nec_transmit #(
`ifdef IR_CARRIER_EN
    .CARRIER_DIV(CD),
`endif
    .LEAD_LO(LL), .LEAD_HI(LH), .BIT_LO(BL), .ZERO_HI(ZH),
    .ONE_HI(OH), .GAP_HI(GH), .CW(CWB)
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .iSTART (start),
    .iCUSTOM(custom),
    .iKEY   (key),
    .oBUSY  (busy),
    .oDONE  (done),
    .oIRDA  (irda),
    .oIR_LED(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] custom;
    logic [7:0]  key;
    logic [31:0] frame;
  } vec_t;

  vec_t vecs[4];

  bit exp_lvl[$];
  int exp_len[$];
  bit got_lvl[$];
  int got_len[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // NEC frame as a list of line runs: leader, (burst, space) per bit LSB first, stop, gap.
  function automatic void build_model(input logic [31:0] w);
    exp_lvl.delete();
    exp_len.delete();
    exp_lvl.push_back(1'b0); exp_len.push_back(LL);
    exp_lvl.push_back(1'b1); exp_len.push_back(LH);
    for (int i = 0; i < 32; i++) begin
      exp_lvl.push_back(1'b0); exp_len.push_back(BL);
      exp_lvl.push_back(1'b1); exp_len.push_back(w[i] ? OH : ZH);
    end
    exp_lvl.push_back(1'b0); exp_len.push_back(BL);
    exp_lvl.push_back(1'b1); exp_len.push_back(GH);
  endfunction

  function automatic bit led_ok(input logic line, input logic l);
`ifdef IR_CARRIER_EN
    return !(line && l);
`else
    return l === ~line;
`endif
  endfunction

  task automatic run_frame(input logic [15:0] c, input logic [7:0] k, input bit do_start,
                           input bit hold, input int poke_at,
                           output logic [31:0] word, output int gap);
    int  led_bad, busy_bad, nseg;
    bit  fin;
    got_lvl.delete();
    got_len.delete();
    led_bad = 0; busy_bad = 0; fin = 1'b0; word = '0; gap = 0;
    if (do_start) begin
      @(negedge clk);
      custom = c; key = k; start = 1'b1;
    end
    for (int n = 0; n < 5000 && !fin; n++) begin
      @(negedge clk);
      if (!hold) start = (n == poke_at);
      if (n == poke_at) begin
        key = 8'h1B; custom = 16'hA5A5;
      end
      if (done === 1'b1) begin
        fin = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (!led_ok(irda, led)) led_bad++;
        if (got_lvl.size() == 0 || got_lvl[$] != irda) begin
          got_lvl.push_back(irda);
          got_len.push_back(1);
        end else begin
          got_len[got_len.size()-1]++;
        end
      end
    end
    chk("done_seen", longint'(fin), 1);
    chk("busy_in_frame", busy_bad, 0);
    chk("led_in_frame", led_bad, 0);
    if (fin) begin
      chk("busy_at_done", longint'(busy), 0);
      chk("line_at_done", longint'(irda), 1);
    end
    build_model({~k, k, c});
    nseg = got_len.size();
    chk("seg_count", nseg, exp_len.size());
    for (int i = 0; i < nseg && i < exp_len.size(); i++) begin
      chk($sformatf("seg%0d_lvl", i), longint'(got_lvl[i]), longint'(exp_lvl[i]));
      chk($sformatf("seg%0d_len", i), got_len[i], exp_len[i]);
    end
    if (nseg == 68) begin
      for (int i = 0; i < 32; i++) word[i] = (got_len[3 + 2*i] > (ZH + OH) / 2);
      gap = got_len[67];
    end
    if (!hold) begin
      @(negedge clk);
      chk("done_one_cycle", longint'(done), 0);
      chk("idle_busy", longint'(busy), 0);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] rc;
    logic [7:0]  rk;
    int          g, bad;

    vecs[0] = '{16'h00FF, 8'h1E, 32'hE11E00FF};
    vecs[1] = '{16'h0000, 8'h0C, 32'hF30C0000};
    vecs[2] = '{16'hFFFF, 8'h00, 32'hFF00FFFF};
    vecs[3] = '{16'h1234, 8'h1B, 32'hE41B1234};

    repeat (3) @(negedge clk);
    chk("rst_irda", longint'(irda), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_led", longint'(led), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].custom, vecs[v].key, 1'b1, 1'b0, -1, w, g);
      chk($sformatf("frame_word_%0d", v), w, vecs[v].frame);
      if (vecs[v].key == 8'h0C) begin
        chk("loop_key", w[23:16], 8'h0C);
        chk("loop_nkey", w[31:24], 8'hF3);
      end
    end

    for (int r = 0; r < 4; r++) begin
      rc = 16'($urandom);
      rk = 8'($urandom);
      run_frame(rc, rk, 1'b1, 1'b0, -1, w, g);
      chk("rand_word", w, {~rk, rk, rc});
    end

    // Start request during the leader space must be ignored, with no follow-up frame.
    run_frame(16'h00FF, 8'h1E, 1'b1, 1'b0, LL + 5, w, g);
    chk("busy_ignore_word", w, 32'hE11E00FF);
    bad = 0;
    for (int n = 0; n < LL + GH; n++) begin
      @(negedge clk);
      if (irda !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("no_second_frame", bad, 0);

    // Held start: back-to-back frames separated by gap plus one idle cycle.
    run_frame(16'h5A3C, 8'h77, 1'b1, 1'b1, -1, w, g);
    chk("b2b_word1", w, {~8'h77, 8'h77, 16'h5A3C});
    chk("b2b_space", g + 1, GH + 1);
    run_frame(16'h5A3C, 8'h77, 1'b0, 1'b0, -1, w, g);
    chk("b2b_word2", w, {~8'h77, 8'h77, 16'h5A3C});

    // Abort in bit 10 with asynchronous reset.
    @(negedge clk);
    custom = 16'h0000; key = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LL + LH + 10 * (BL + ZH) + 1) @(negedge clk);
    chk("abort_busy_before", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_irda", longint'(irda), 1);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_led", longint'(led), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || irda !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    run_frame(16'hC0DE, 8'h42, 1'b1, 1'b0, -1, w, g);
    chk("after_abort_word", w, {~8'h42, 8'h42, 16'hC0DE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
